// File: rtl/riscv_pkg.sv
// Shared integer-pipeline constants and types for the RISC-V core.
// Consumed by the register file and its busy-bit scoreboard.
package riscv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register marking an in-flight write.
// Flush beats issue, issue beats writeback clear, and x0 is never busy.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter  int NREGS = NREGS_DEFAULT,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             busy_any
);

  logic [NREGS-1:0] busy_next;

  always_comb begin
    // NOTE: default assigned first so every path drives busy_next and no latch is inferred.
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (we) busy_next[wa] = 1'b0;
      // The issuing instruction is younger than the one writing back, so it wins.
      if (issue_valid) busy_next[issue_rd] = 1'b1;
    end
    busy_next[AW'(ZERO_REG)] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  assign busy_any = |busy;

endmodule

// File: rtl/pipe_regfile.sv
// Integer register file with NRD combinational read ports, one write port and a busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle writeback forwarding onto the read ports.
module pipe_regfile
  import riscv_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      hazard,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                flush,
  output logic                busy_any
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             write_en;

  assign write_en = we && (wa != AW'(ZERO_REG));

  // NOTE: the array carries a reset because post-reset reads must return zero; it stays in flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[wa] <= wd;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .we          (we),
    .wa          (wa),
    .flush       (flush),
    .busy        (busy),
    .busy_any    (busy_any)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_read
    logic [AW-1:0] addr;
    logic          is_zero;

    assign addr    = ra[k*AW +: AW];
    assign is_zero = (addr == AW'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
    // Writeback to the same register is forwarded, so the consumer needs no bubble.
    logic fwd;
    assign fwd                 = write_en && (wa == addr);
    assign rd[k*XLEN +: XLEN]  = is_zero ? '0 : (fwd ? wd : regs[addr]);
    assign hazard[k]           = busy[addr] && !fwd;
`else
    assign rd[k*XLEN +: XLEN]  = is_zero ? '0 : regs[addr];
    assign hazard[k]           = busy[addr];
`endif
  end

endmodule

// File: tb/tb_pipe_regfile.sv
// Self-checking bench for pipe_regfile: directed scenarios plus random traffic,
// checked through an expectation queue against a behavioural model of the register file.
module tb_pipe_regfile;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      hazard;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                flush;
  logic                busy_any;

  pipe_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk         (clk),
    .reset       (reset),
    .ra          (ra),
    .rd          (rd),
    .hazard      (hazard),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .busy_any    (busy_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                name;
    logic [NRD*XLEN-1:0]  rd;
    logic [NRD-1:0]       hz;
    logic                 ba;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: architectural state as plain arrays
  logic [XLEN-1:0] m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  bit               model_known = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the stimulus side queued, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".rd0"}, 64'(rd[0 +: XLEN]), 64'(e.rd[0 +: XLEN]));
        check({e.name, ".rd1"}, 64'(rd[XLEN +: XLEN]), 64'(e.rd[XLEN +: XLEN]));
        check({e.name, ".hazard"}, 64'(hazard), 64'(e.hz));
        check({e.name, ".busy_any"}, 64'(busy_any), 64'(e.ba));
      end
    end
  end

  function automatic exp_t predict(input string name);
    exp_t e;
    logic [AW-1:0] a;
    e.name = name;
    e.rd   = '0;
    e.hz   = '0;
    for (int k = 0; k < NRD; k++) begin
      a = ra[k*AW +: AW];
      if (a == 0) begin
        e.rd[k*XLEN +: XLEN] = '0;
        e.hz[k]              = 1'b0;
      end else if (BYPASS && we && wa != 0 && wa == a) begin
        e.rd[k*XLEN +: XLEN] = wd;
        e.hz[k]              = 1'b0;
      end else begin
        e.rd[k*XLEN +: XLEN] = m_regs[a];
        e.hz[k]              = m_busy[a];
      end
    end
    e.ba = (m_busy != 0);
    return e;
  endfunction

  // One clock: queue expectations for the present inputs, then apply the edge to the model
  task automatic cycle(input string name);
    if (model_known && !reset) exp_q.push_back(predict(name));
    @(posedge clk);
    #1;
    if (reset) begin
      for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
      m_busy      = '0;
      model_known = 1'b1;
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      for (int r = 1; r < NREGS; r++) begin
        if (!flush && issue_valid && issue_rd == AW'(r)) m_busy[r] = 1'b1;
        else if (flush || (we && wa == AW'(r)))          m_busy[r] = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    reset = 1'b0; we = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    wa = '0; wd = '0; issue_rd = '0;
    ra = {r1, r0};
  endtask

  initial begin
    idle(5'd5, 5'd0);
    // Reset with a write and an issue held on the ports: both must be ignored
    reset = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; issue_valid = 1'b1; issue_rd = 5'd3;
    cycle("reset");
    idle(5'd5, 5'd0);
    cycle("after_reset");

    // Plain write/read and discarded write to x0
    idle(5'd0, 5'd0); we = 1'b1; wa = 5'd7; wd = 32'h12345678;
    cycle("wr_x7");
    idle(5'd7, 5'd0); we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    cycle("rd_x7_wr_x0");
    idle(5'd7, 5'd0);
    cycle("rd_x0");

    // Scoreboard set then writeback clear
    idle(5'd0, 5'd0); issue_valid = 1'b1; issue_rd = 5'd3;
    cycle("issue_x3");
    idle(5'd3, 5'd0);
    cycle("hazard_x3");
    idle(5'd3, 5'd0); we = 1'b1; wa = 5'd3; wd = 32'hA5;
    cycle("wb_x3");
    idle(5'd3, 5'd0);
    cycle("after_wb_x3");

    // Same-cycle issue and writeback to one register
    idle(5'd4, 5'd0); issue_valid = 1'b1; issue_rd = 5'd4;
    cycle("issue_x4");
    idle(5'd4, 5'd0); issue_valid = 1'b1; issue_rd = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h4444;
    cycle("collide_x4");
    idle(5'd4, 5'd0);
    cycle("after_collide");

    // Flush beats a concurrent issue
    idle(5'd0, 5'd0);
    foreach (ra[i]) ra[i] = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd1;  cycle("issue_x1");
    issue_rd = 5'd2;                      cycle("issue_x2");
    issue_rd = 5'd31;                     cycle("issue_x31");
    idle(5'd1, 5'd31); flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd9;
    cycle("flush");
    idle(5'd9, 5'd2);
    cycle("after_flush");

    // Writeback cycle seen from a read port (forwarded or old value)
    idle(5'd0, 5'd6); we = 1'b1; wa = 5'd6; wd = 32'h66;
    cycle("wr_x6");
    idle(5'd0, 5'd6); issue_valid = 1'b1; issue_rd = 5'd6;
    cycle("issue_x6");
    idle(5'd0, 5'd6); we = 1'b1; wa = 5'd6; wd = 32'h55;
    cycle("wb_x6_bypass");
    idle(5'd6, 5'd6);
    cycle("after_wb_x6");

    // Random traffic, including occasional mid-run reset and flush
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(63) == 0);
      flush       = ($urandom_range(15) == 0);
      we          = $urandom_range(1);
      wa          = AW'($urandom_range(NREGS - 1));
      wd          = $urandom;
      issue_valid = $urandom_range(1);
      issue_rd    = AW'($urandom_range(NREGS - 1));
      for (int k = 0; k < NRD; k++)
        ra[k*AW +: AW] = ($urandom_range(2) == 0) ? wa : AW'($urandom_range(NREGS - 1));
      cycle("random");
    end

    idle(5'd0, 5'd0);
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
